// File: rtl/pow_check_pkg.sv
// Shared definitions for the pow_check block: default data width and FSM state encoding.
package pow_check_pkg;

    localparam int W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pow_check_sat_mul.sv
// Combinational W x W multiply returning the low W bits and a flag for a nonzero upper half.
module sat_mul #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic         ovf
);

    logic [2*W-1:0] prod;

    always_comb begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        lo   = prod[W-1:0];
        ovf  = |prod[2*W-1:W];
    end

endmodule

// File: rtl/pow_check.sv
// Recomputes c^g by repeated multiplication with saturation and qualifies the result against j.
module pow_check
    import pow_check_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] c,
    input  logic [W-1:0] g,
    input  logic [W-1:0] j,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] power,
    output logic         exact,
    output logic         ge,
    output logic         ovf
);

    state_e       state_q, state_d;
    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] c_q, c_d;
    logic [W-1:0] j_q, j_d;
    logic [W-1:0] power_q, power_d;
    logic         exact_q, exact_d;
    logic         ge_q, ge_d;
    logic         ovf_q, ovf_d;

    logic [W-1:0] mul_lo;
    logic         mul_ovf;
    logic         ovf_hit;
    logic         load_res;

    sat_mul #(.W(W)) u_sat_mul (
        .a   (acc_q),
        .b   (c_q),
        .lo  (mul_lo),
        .ovf (mul_ovf)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        j_d     = j_q;
        ovf_hit = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d     = c;
                    j_d     = j;
                    acc_d   = {{(W-1){1'b0}}, 1'b1};
                    cnt_d   = g;
                    state_d = (g == '0) ? DONE : MULT;
                end
            end
            MULT: begin
                // An overflowing multiply ends the run early; later multiplies cannot shrink it.
                if (mul_ovf) begin
                    acc_d   = '1;
                    ovf_hit = 1'b1;
                    state_d = DONE;
                end else begin
                    acc_d = mul_lo;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == {{(W-1){1'b0}}, 1'b1}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result registers load on the edge entering DONE so they line up with the done pulse.
    always_comb begin
        load_res = (state_d == DONE) && (state_q != DONE);
        power_d  = power_q;
        exact_d  = exact_q;
        ge_d     = ge_q;
        ovf_d    = ovf_q;
        if (load_res) begin
            power_d = acc_d;
            ovf_d   = ovf_hit;
            exact_d = !ovf_hit && (acc_d == j_d);
            ge_d    = ovf_hit || (acc_d >= j_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            j_q     <= '0;
            power_q <= '0;
            exact_q <= 1'b0;
            ge_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            j_q     <= j_d;
            power_q <= power_d;
            exact_q <= exact_d;
            ge_q    <= ge_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign power = power_q;
    assign exact = exact_q;
    assign ge    = ge_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_pow_check.sv
// Directed bench for pow_check: hand-computed powers, latency, overflow, busy-ignore and reset abort.
module tb_pow_check;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] c;
    logic [15:0] g;
    logic [15:0] j;
    logic        busy;
    logic        done;
    logic [15:0] power;
    logic        exact;
    logic        ge;
    logic        ovf;

    int          pass_cnt;
    int          total_cnt;
    logic [15:0] hold_power;

    pow_check #(.W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .c     (c),
        .g     (g),
        .j     (j),
        .busy  (busy),
        .done  (done),
        .power (power),
        .exact (exact),
        .ge    (ge),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Issue one request; glitch_at > 0 pulses a bogus start sampled at that edge index.
    task automatic req(input logic [15:0] ci, input logic [15:0] gi, input logic [15:0] ji,
                       input int exp_n, input logic [15:0] exp_pow,
                       input logic exp_exact, input logic exp_ge, input logic exp_ovf,
                       input int glitch_at);
        int e;
        c = ci; g = gi; j = ji; start = 1'b1;
        tick();
        start = 1'b0;
        c = $urandom_range(0, 65535);
        g = $urandom_range(0, 65535);
        j = $urandom_range(0, 65535);
        chk("busy_after_start", busy, 1'b1);
        if (exp_n > 0) chk("power_held", power, hold_power);
        e = 0;
        while (!done && e < 60) begin
            if (glitch_at > 0 && e + 1 == glitch_at) begin
                start = 1'b1; c = 16'd9; g = 16'd1; j = 16'd9;
            end
            tick();
            start = 1'b0;
            e++;
        end
        chk("done_edge", e, exp_n);
        chk("power", power, exp_pow);
        chk("exact", exact, exp_exact);
        chk("ge", ge, exp_ge);
        chk("ovf", ovf, exp_ovf);
        hold_power = exp_pow;
        tick();
        chk("done_one_cycle", done, 1'b0);
        chk("idle_not_busy", busy, 1'b0);
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        hold_power = 16'd0;
        rst_n = 1'b0;
        start = 1'b0;
        c = '0; g = '0; j = '0;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_power", power, 16'd0);
        chk("rst_exact", exact, 1'b0);
        chk("rst_ge", ge, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        tick();

        req(16'd3, 16'd4, 16'd81, 4, 16'd81, 1'b1, 1'b1, 1'b0, 0);
        req(16'd5, 16'd0, 16'd7, 0, 16'd1, 1'b0, 1'b0, 1'b0, 0);
        req(16'd2, 16'd17, 16'd100, 16, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0);
        req(16'd3, 16'd5, 16'd200, 5, 16'd243, 1'b0, 1'b1, 1'b0, 0);
        req(16'd3, 16'd4, 16'd200, 4, 16'd81, 1'b0, 1'b0, 1'b0, 0);
        req(16'd2, 16'd6, 16'd64, 6, 16'd64, 1'b1, 1'b1, 1'b0, 3);
        req(16'd7, 16'd2, 16'd49, 2, 16'd49, 1'b1, 1'b1, 1'b0, 0);
        req(16'd0, 16'd3, 16'd0, 3, 16'd0, 1'b1, 1'b1, 1'b0, 0);
        req(16'd1, 16'd10, 16'd2, 10, 16'd1, 1'b0, 1'b0, 1'b0, 0);
        req(16'd255, 16'd2, 16'd65025, 2, 16'd65025, 1'b1, 1'b1, 1'b0, 0);
        req(16'd256, 16'd2, 16'd5, 2, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0);
        req(16'd16, 16'd4, 16'hFFFF, 4, 16'hFFFF, 1'b0, 1'b1, 1'b1, 0);

        // Abort mid-MULT: c=3, g=8, reset between edges 4 and 5.
        c = 16'd3; g = 16'd8; j = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("abort_busy_before", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_power", power, 16'd0);
        chk("abort_exact", exact, 1'b0);
        chk("abort_ge", ge, 1'b0);
        chk("abort_ovf", ovf, 1'b0);
        hold_power = 16'd0;
        tick();
        chk("abort_no_done", done, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("abort_still_idle", busy, 1'b0);
        req(16'd3, 16'd8, 16'd6561, 8, 16'd6561, 1'b1, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
